// File: rtl/handler_s00_axi_regs_if.sv
// AXI4-Lite bus bundle for the Handler S00_AXI port.
// The master modport is the block-design side; the slave modport is the register bank.
interface handler_s00_axi_regs_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
);

  // Write address channel
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;

  // Write data channel
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;

  // Write response channel
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;

  // Read address channel
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;

  // Read data channel
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

// File: rtl/handler_s00_axi_regs.sv
// AXI4-Lite slave register bank for the Handler IP: four 32-bit registers at 0x0/0x4/0x8/0xC
// with per-register write pulses. Write and read channels are independent single-outstanding FSMs.
// Optional feature macro: HANDLER_ADDR_DECODE_ERR_EN -- when defined, accesses with addr[4]=1
// are rejected with SLVERR; otherwise addr[4] is ignored and the access aliases onto addr[3:2].
module handler_s00_axi_regs #(
  parameter int unsigned                C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned                C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_RESET_VAL    = '0
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  handler_s00_axi_regs_if.slave         s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] REG0_OUT,
  output logic [C_S_AXI_DATA_WIDTH-1:0] REG1_OUT,
  output logic [C_S_AXI_DATA_WIDTH-1:0] REG2_OUT,
  output logic [C_S_AXI_DATA_WIDTH-1:0] REG3_OUT,
  output logic [3:0]                    REG_WR_PULSE
);

  localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;

`ifdef HANDLER_ADDR_DECODE_ERR_EN
  localparam bit DecodeErrEn = 1'b1;
`else
  localparam bit DecodeErrEn = 1'b0;
`endif

  typedef enum logic [1:0] {StWIdle, StWCollect, StWCommit, StWResp} w_state_e;
  typedef enum logic       {StRIdle, StRData} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];

  // Captured write transaction
  logic                          aw_held_q, aw_held_d;
  logic                          w_held_q, w_held_d;
  logic [1:0]                    aw_idx_q, aw_idx_d;
  logic                          aw_err_q, aw_err_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]              wstrb_q, wstrb_d;

  logic [1:0]                    bresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                    rresp_q;
  logic [3:0]                    wr_pulse_q;

  // Holds all READY outputs low for the first cycle after reset releases.
  logic live_q;

  logic awready, wready, bvalid, aw_fire, w_fire;
  logic arready, rvalid, ar_fire;
  logic [1:0] ar_idx;
  logic ar_err;
  logic commit;

  // Protection bits and the unaligned address LSBs carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};

  // Out-of-reset flag gating the READY outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  // Write FSM state and capture registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= StWIdle;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= 2'd0;
      aw_err_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_err_q  <= aw_err_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // Write FSM next state: AW and W are captured independently, then committed together.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    aw_err_d  = aw_err_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    unique case (w_state_q)
      StWIdle, StWCollect: begin
        awready = live_q & ~aw_held_q;
        wready  = live_q & ~w_held_q;
        aw_fire = awready & s_axi.S_AXI_AWVALID;
        w_fire  = wready & s_axi.S_AXI_WVALID;
        if (aw_fire) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s_axi.S_AXI_AWADDR[3:2];
          aw_err_d  = DecodeErrEn & s_axi.S_AXI_AWADDR[4];
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.S_AXI_WDATA;
          wstrb_d  = s_axi.S_AXI_WSTRB;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = StWCommit;
        end else if (aw_held_d || w_held_d) begin
          w_state_d = StWCollect;
        end
      end
      StWCommit: begin
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        w_state_d = StWResp;
      end
      StWResp: begin
        bvalid = 1'b1;
        if (s_axi.S_AXI_BREADY) begin
          w_state_d = StWIdle;
        end
      end
      default: w_state_d = StWIdle;
    endcase
  end

  assign commit = (w_state_q == StWCommit);

  // Register file update, write pulse and write response
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= C_RESET_VAL;
      end
      wr_pulse_q <= 4'd0;
      bresp_q    <= RespOkay;
    end else begin
      wr_pulse_q <= 4'd0;
      if (commit) begin
        bresp_q <= aw_err_q ? RespSlverr : RespOkay;
        if (!aw_err_q) begin
          for (int b = 0; b < int'(StrbW); b++) begin
            if (wstrb_q[b]) begin
              regs_q[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
          end
          wr_pulse_q[aw_idx_q] <= 1'b1;
        end
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= StRIdle;
    end else begin
      r_state_q <= r_state_d;
    end
  end

  // Read FSM next state: accept AR in idle, hold R until the master takes it.
  always_comb begin
    r_state_d = r_state_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    ar_fire   = 1'b0;
    unique case (r_state_q)
      StRIdle: begin
        arready = live_q;
        ar_fire = arready & s_axi.S_AXI_ARVALID;
        if (ar_fire) begin
          r_state_d = StRData;
        end
      end
      StRData: begin
        rvalid = 1'b1;
        if (s_axi.S_AXI_RREADY) begin
          r_state_d = StRIdle;
        end
      end
      default: r_state_d = StRIdle;
    endcase
  end

  assign ar_idx = s_axi.S_AXI_ARADDR[3:2];
  assign ar_err = DecodeErrEn & s_axi.S_AXI_ARADDR[4];

  // Read data capture; sampling regs_q at the commit edge yields the pre-write value.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdata_q <= '0;
      rresp_q <= RespOkay;
    end else if (ar_fire) begin
      rdata_q <= ar_err ? '0 : regs_q[ar_idx];
      rresp_q <= ar_err ? RespSlverr : RespOkay;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

  assign REG0_OUT     = regs_q[0];
  assign REG1_OUT     = regs_q[1];
  assign REG2_OUT     = regs_q[2];
  assign REG3_OUT     = regs_q[3];
  assign REG_WR_PULSE = wr_pulse_q;

endmodule

// File: tb/tb_handler_s00_axi_regs.sv
// Directed self-checking bench for handler_s00_axi_regs (reset value 0).
module tb_handler_s00_axi_regs;

  logic        clk;
  logic        rst;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  wr_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt [4];

  handler_s00_axi_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) axi ();

  handler_s00_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .C_RESET_VAL       (32'h0)
  ) dut (
    .ACLK        (clk),
    .ARESET      (rst),
    .s_axi       (axi),
    .REG0_OUT    (reg0),
    .REG1_OUT    (reg1),
    .REG2_OUT    (reg2),
    .REG3_OUT    (reg3),
    .REG_WR_PULSE(wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write pulses per register, one sample per cycle
  initial begin
    for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
  end
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    logic aw_done, w_done, aw_fire, w_fire;
    @(negedge clk);
    axi.S_AXI_AWADDR  = addr;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA   = data;
    axi.S_AXI_WSTRB   = strb;
    axi.S_AXI_WVALID  = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_fire = axi.S_AXI_AWVALID & axi.S_AXI_AWREADY;
      w_fire  = axi.S_AXI_WVALID & axi.S_AXI_WREADY;
      @(negedge clk);
      if (aw_fire) begin axi.S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_fire) begin axi.S_AXI_WVALID = 1'b0; w_done = 1'b1; end
      n++;
    end
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    check("wr_accept", {31'd0, aw_done & w_done}, 32'd1);
    axi.S_AXI_BREADY = 1'b1;
    n = 0;
    while (!axi.S_AXI_BVALID && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wr_bvalid", {31'd0, axi.S_AXI_BVALID}, 32'd1);
    resp = axi.S_AXI_BRESP;
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    logic done, fire;
    @(negedge clk);
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      fire = axi.S_AXI_ARVALID & axi.S_AXI_ARREADY;
      @(negedge clk);
      if (fire) begin axi.S_AXI_ARVALID = 1'b0; done = 1'b1; end
      n++;
    end
    axi.S_AXI_ARVALID = 1'b0;
    check("rd_accept", {31'd0, done}, 32'd1);
    // One-cycle latency: RVALID already up at the first sample after the handshake
    check("rd_latency", {31'd0, axi.S_AXI_RVALID}, 32'd1);
    data = axi.S_AXI_RDATA;
    resp = axi.S_AXI_RRESP;
    axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
  endtask

  // One channel first, the other after a gap; the captured channel's READY must stay low.
  task automatic write_split(input logic [4:0] addr, input logic [31:0] data, input bit aw_first,
                             input int gap, output logic [1:0] resp);
    int n;
    logic fire, done;
    @(negedge clk);
    axi.S_AXI_AWADDR = addr;
    axi.S_AXI_WDATA  = data;
    axi.S_AXI_WSTRB  = 4'hF;
    if (aw_first) axi.S_AXI_AWVALID = 1'b1;
    else axi.S_AXI_WVALID = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      fire = aw_first ? axi.S_AXI_AWREADY : axi.S_AXI_WREADY;
      @(negedge clk);
      if (fire) done = 1'b1;
      n++;
    end
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    check("split_first", {31'd0, done}, 32'd1);
    for (int k = 0; k < gap; k++) begin
      check("split_held_rdy", {31'd0, aw_first ? axi.S_AXI_AWREADY : axi.S_AXI_WREADY}, 32'd0);
      check("split_other_rdy", {31'd0, aw_first ? axi.S_AXI_WREADY : axi.S_AXI_AWREADY}, 32'd1);
      check("split_no_b", {31'd0, axi.S_AXI_BVALID}, 32'd0);
      if (k != gap - 1) @(negedge clk);
    end
    if (aw_first) axi.S_AXI_WVALID = 1'b1;
    else axi.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b1;
    n = 0;
    while (!axi.S_AXI_BVALID && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("split_bvalid", {31'd0, axi.S_AXI_BVALID}, 32'd1);
    resp = axi.S_AXI_BRESP;
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
  endtask

  logic [1:0]  resp;
  logic [31:0] data;
  int          base [4];

  initial begin
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA  = '0; axi.S_AXI_WSTRB  = '0; axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd0);
    check("rst_wready", {31'd0, axi.S_AXI_WREADY}, 32'd0);
    check("rst_arready", {31'd0, axi.S_AXI_ARREADY}, 32'd0);
    check("rst_bvalid", {31'd0, axi.S_AXI_BVALID}, 32'd0);
    check("rst_rvalid", {31'd0, axi.S_AXI_RVALID}, 32'd0);
    check("rst_rdata", axi.S_AXI_RDATA, 32'd0);
    check("rst_reg0", reg0, 32'd0);
    check("rst_pulse", {28'd0, wr_pulse}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd1);
    check("post_rst_arready", {31'd0, axi.S_AXI_ARREADY}, 32'd1);

    // Sequential write then readback
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp);
      check("seq_bresp", {30'd0, resp}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      check("seq_pulse_cnt", pulse_cnt[i], 32'd1);
      axi_read(5'(i * 4), data, resp);
      check("seq_rdata", data, 32'(i + 1));
      check("seq_rresp", {30'd0, resp}, 32'd0);
    end
    check("seq_reg3_out", reg3, 32'd4);

    // Partial strobe
    axi_write(5'h04, 32'hAABBCCDD, 4'hF, resp);
    axi_write(5'h04, 32'h11223344, 4'b0101, resp);
    axi_read(5'h04, data, resp);
    check("strb_rdata", data, 32'hAA22CC44);
    check("strb_reg1_out", reg1, 32'hAA22CC44);
    axi_read(5'h07, data, resp);
    check("unaligned_rdata", data, 32'hAA22CC44);

    // Simultaneous AW+W, with a read of the same register landing on the commit edge
    @(negedge clk);
    axi.S_AXI_AWADDR = 5'h08; axi.S_AXI_WDATA = 32'h5A5A0000; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    check("both_ready", {30'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 32'd3);
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    check("commit_no_b", {31'd0, axi.S_AXI_BVALID}, 32'd0);
    check("commit_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd0);
    axi.S_AXI_ARADDR = 5'h08; axi.S_AXI_ARVALID = 1'b1;
    check("commit_arready", {31'd0, axi.S_AXI_ARREADY}, 32'd1);
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    check("b_latency", {31'd0, axi.S_AXI_BVALID}, 32'd1);
    check("r_latency", {31'd0, axi.S_AXI_RVALID}, 32'd1);
    check("r_prewrite", axi.S_AXI_RDATA, 32'd3);
    check("reg2_updated", reg2, 32'h5A5A0000);
    check("pulse_reg2", {28'd0, wr_pulse}, 32'b0100);
    axi.S_AXI_RREADY = 1'b1; axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0; axi.S_AXI_BREADY = 1'b0;
    check("pulse_one_cycle", {28'd0, wr_pulse}, 32'd0);
    check("b_done", {31'd0, axi.S_AXI_BVALID}, 32'd0);
    check("r_done", {31'd0, axi.S_AXI_RVALID}, 32'd0);
    axi_read(5'h08, data, resp);
    check("r_postwrite", data, 32'h5A5A0000);

    // AW leads W by 3 cycles, then W leads AW by 3 cycles
    for (int i = 0; i < 4; i++) base[i] = pulse_cnt[i];
    write_split(5'h0C, 32'hC0FFEE01, 1'b1, 3, resp);
    check("split_aw_bresp", {30'd0, resp}, 32'd0);
    repeat (2) @(negedge clk);
    check("split_aw_one_b", {31'd0, axi.S_AXI_BVALID}, 32'd0);
    check("split_aw_pulse", pulse_cnt[3] - base[3], 32'd1);
    check("split_aw_reg3", reg3, 32'hC0FFEE01);
    write_split(5'h00, 32'h0BADF00D, 1'b0, 3, resp);
    check("split_w_bresp", {30'd0, resp}, 32'd0);
    repeat (2) @(negedge clk);
    check("split_w_one_b", {31'd0, axi.S_AXI_BVALID}, 32'd0);
    check("split_w_pulse", pulse_cnt[0] - base[0], 32'd1);
    check("split_w_reg0", reg0, 32'h0BADF00D);

    // B back-pressure for 10 cycles while a read completes
    @(negedge clk);
    axi.S_AXI_AWADDR = 5'h04; axi.S_AXI_WDATA = 32'h12345678; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("bp_bvalid", {31'd0, axi.S_AXI_BVALID}, 32'd1);
      check("bp_bresp", {30'd0, axi.S_AXI_BRESP}, 32'd0);
      check("bp_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd0);
      check("bp_wready", {31'd0, axi.S_AXI_WREADY}, 32'd0);
      if (k == 2) begin
        check("bp_arready", {31'd0, axi.S_AXI_ARREADY}, 32'd1);
        axi.S_AXI_ARADDR = 5'h00; axi.S_AXI_ARVALID = 1'b1;
      end
      if (k == 3) begin
        axi.S_AXI_ARVALID = 1'b0;
        check("bp_rvalid", {31'd0, axi.S_AXI_RVALID}, 32'd1);
        check("bp_rdata", axi.S_AXI_RDATA, 32'h0BADF00D);
        axi.S_AXI_RREADY = 1'b1;
      end
      if (k == 4) begin
        axi.S_AXI_RREADY = 1'b0;
        check("bp_rdone", {31'd0, axi.S_AXI_RVALID}, 32'd0);
      end
      @(negedge clk);
    end
    axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
    check("bp_bdone", {31'd0, axi.S_AXI_BVALID}, 32'd0);
    check("bp_reg1", reg1, 32'h12345678);

    // Reset in the middle of a write: AW accepted, W never sent
    @(negedge clk);
    axi.S_AXI_AWADDR = 5'h00; axi.S_AXI_AWVALID = 1'b1;
    check("mid_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd1);
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    check("mid_aw_held", {31'd0, axi.S_AXI_AWREADY}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reg0", reg0, 32'd0);
    check("mid_reg1", reg1, 32'd0);
    check("mid_reg2", reg2, 32'd0);
    check("mid_reg3", reg3, 32'd0);
    @(negedge clk);
    check("mid_awready_after", {31'd0, axi.S_AXI_AWREADY}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("mid_no_b", {31'd0, axi.S_AXI_BVALID}, 32'd0);
      @(negedge clk);
    end

    // Out-of-range window
    axi_write(5'h00, 32'h00000077, 4'hF, resp);
    axi_write(5'h10, 32'h0000DEAD, 4'hF, resp);
`ifdef HANDLER_ADDR_DECODE_ERR_EN
    check("oor_bresp", {30'd0, resp}, 32'h2);
    check("oor_reg0", reg0, 32'h00000077);
    axi_read(5'h10, data, resp);
    check("oor_rdata", data, 32'h0);
    check("oor_rresp", {30'd0, resp}, 32'h2);
`else
    check("oor_bresp", {30'd0, resp}, 32'h0);
    check("oor_reg0", reg0, 32'h0000DEAD);
    axi_read(5'h10, data, resp);
    check("oor_rdata", data, 32'h0000DEAD);
    check("oor_rresp", {30'd0, resp}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
